stopwatch_timebase_ctrl: RTL and testbench
==========================================

// Module: stopwatch_timebase_ctrl
// PURPOSE
//  Sequences the stopwatch time datapath from the run/hold/idle code en[1:0] produced by the
//  stopwatch control FSM. Contains the clock prescaler that produces a centisecond tick and the
//  BCD counter cascade MM:SS.CC. Drives the BCD digits to the display mux.
//  Sits between the control FSM and the 7-segment display driver.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock frequency
//  TICK_HZ  100         count rate in Hz (one count per centisecond)
//  DIV      CLK_HZ/TICK_HZ  derived prescaler modulus; must be >= 2
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  hard_reset in   1  synchronous active-low reset
//  soft_reset in   1  synchronous active-low clear: same effect as en==00
//  en         in   2  00 idle(clear), 01 run, 10 hold, 11 = treated as 00
//  lap        in   1  single-cycle lap request pulse (used only with LAP_CAPTURE_EN)
//  cs_ones    out  4  centiseconds units, BCD 0-9
//  cs_tens    out  4  centiseconds tens, BCD 0-9
//  sec_ones   out  4  seconds units, BCD 0-9
//  sec_tens   out  4  seconds tens, BCD 0-5
//  min_ones   out  4  minutes units, BCD 0-9
//  min_tens   out  4  minutes tens, BCD 0-5
//  tick       out  1  one-cycle pulse, high in the cycle the count has just advanced
//  running    out  1  registered: 1 while en==01
//  overflow   out  1  sticky: set when 59:59.99 wraps to 00:00.00
//  lap_active out  1  1 while the digit outputs are frozen on a lap snapshot
// BEHAVIOUR
//  - Reset (hard_reset==0 at clk edge): prescaler=0; all digits 0; tick, running, overflow,
//    lap_active 0. Every output is registered.
//  - Clear condition: soft_reset==0, en==00 or en==11. At the next edge: prescaler=0,
//    digits=0, overflow=0, lap_active=0, tick=0, running=0. Clear beats run and lap.
//  - Run (en==01, not clear): prescaler counts 0..DIV-1 and wraps to 0. At the edge where
//    prescaler==DIV-1: the BCD cascade increments by one centisecond and tick=1 for exactly one
//    cycle. The first tick occurs DIV cycles after en becomes 01 from a cleared state.
//  - Hold (en==10): prescaler and digits freeze at their current values; tick=0. A return to
//    run resumes from the frozen prescaler value. The partial period is preserved, not restarted.
//  - Cascade: cs_ones wraps 9->0 and carries into cs_tens. cs_tens 9->0 carries into sec_ones.
//    sec_ones 9->0 carries into sec_tens. sec_tens 5->0 carries into min_ones. min_ones 9->0
//    carries into min_tens. min_tens 5->0 together with the other wraps is the full
//    59:59.99 -> 00:00.00 wrap. That wrap sets overflow=1 and counting continues.
//    Every digit updates on the same edge; no intermediate non-BCD values are ever visible.
//  - en changes take effect on the edge where they are sampled. There is no extra pipeline stage.
//  - Reset or clear mid-count abandons the partial prescaler period immediately.
// CONFIGURATION
//  LAP_CAPTURE_EN defined:
//    - A lap pulse while en==01 or 10, with lap_active==0, has this effect at the next edge:
//      the digit outputs latch the current count and lap_active=1. The internal count keeps
//      running. tick still pulses.
//    - A lap pulse while lap_active==1 releases the freeze at the next edge. The outputs show
//      the live count again and lap_active=0.
//    - A lap pulse in idle is ignored. A clear releases the freeze.
//    - A lap pulse coincident with a tick snapshots the post-increment value.
//  LAP_CAPTURE_EN undefined: lap is ignored; lap_active is tied 0; the outputs always show
//    the live count.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> DIV=10)
//  - hard_reset low 3 cycles, en=01 -> all digits 0 during reset; first tick 10 cycles after
//    release; cs_ones=1.
//  - Run 1000 ticks -> digits 00:10.00; tick asserted exactly every 10th cycle, never 2 in a row.
//  - Run 4 cycles, en=10 for 50 cycles, en=01 -> no tick during hold; next tick 6 cycles after
//    resume.
//  - Preload via run to 59:59.99, 1 more tick -> 00:00.00, overflow=1; en=00 -> overflow=0,
//    digits 0.
//  - en=01 with soft_reset pulsed low 1 cycle mid-count -> next edge digits 0, prescaler 0;
//    counting restarts; en=11 behaves as idle.
//  - LAP_CAPTURE_EN: lap at 00:01.23 -> outputs hold 01.23 and lap_active=1 while running;
//    lap again at internal 00:02.00 -> outputs 02.00 live; lap in idle -> no change.

Source files
------------

// File: rtl/stopwatch_timebase_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_timebase_ctrl
// Time datapath for the stopwatch. It has a clock prescaler that produces a
// centisecond tick and a BCD counter cascade for MM:SS.CC. It drives the BCD
// digits to the display mux.
//
// Optional feature: define LAP_CAPTURE_EN to enable lap snapshot capture.
//
// Ports
//   clk         in  1  system clock, all logic on posedge
//   hard_reset  in  1  synchronous active-low reset
//   soft_reset  in  1  synchronous active-low clear (same effect as en==00)
//   en          in  2  00 idle/clear, 01 run, 10 hold, 11 idle/clear
//   lap         in  1  single-cycle lap request (LAP_CAPTURE_EN only)
//   cs_ones..min_tens  out 4 each  BCD digits of MM:SS.CC
//   tick        out 1  high for one cycle after each count advance
//   running     out 1  high while en==01 was sampled (and no clear)
//   overflow    out 1  sticky, set on the 59:59.99 -> 00:00.00 wrap
//   lap_active  out 1  digit outputs frozen on a lap snapshot
// ---------------------------------------------------------------------------
module stopwatch_timebase_ctrl #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       hard_reset,
  input  logic       soft_reset,
  input  logic [1:0] en,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       tick,
  output logic       running,
  output logic       overflow,
  output logic       lap_active
);

  localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
  localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW   = 4;
  localparam int unsigned NDIG = 6;
  localparam int unsigned CW   = NDIG * DW;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // Per-digit wrap value, digit 0 (cs_ones) in the low nibble.
  localparam logic [CW-1:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  // Packed count: {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}
  logic [CW-1:0] cnt;
  logic [PW-1:0] presc;

  logic          clear_c;
  logic          run_c;
  logic          step_c;
  logic          cnt_wrap_c;
  logic [CW-1:0] cnt_inc_c;
  logic [CW-1:0] cnt_next_c;
  logic [PW-1:0] presc_next_c;

  // Ripple-carry BCD increment over all digits; MSB of result is the full wrap.
  function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    logic          carry;
    logic [DW-1:0] d;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < int'(NDIG); i++) begin
      d = c[i*DW +: DW];
      if (carry) begin
        if (d >= DIGIT_MAX[i*DW +: DW]) begin
          r[i*DW +: DW] = '0;
        end else begin
          r[i*DW +: DW] = d + DW'(1);
          carry         = 1'b0;
        end
      end
    end
    return {carry, r};
  endfunction

  // Next prescaler and count values.
  always_comb begin
    clear_c      = ~soft_reset | (en == 2'b00) | (en == 2'b11);
    run_c        = ~clear_c & (en == 2'b01);
    step_c       = run_c & (presc == PRESC_LAST);
    {cnt_wrap_c, cnt_inc_c} = bcd_inc(cnt);
    presc_next_c = presc;
    cnt_next_c   = cnt;
    if (clear_c) begin
      presc_next_c = '0;
      cnt_next_c   = '0;
    end else if (step_c) begin
      presc_next_c = '0;
      cnt_next_c   = cnt_inc_c;
    end else if (run_c) begin
      presc_next_c = presc + PW'(1);
    end
  end

  // Prescaler, live count and status flags.
  always_ff @(posedge clk) begin
    if (!hard_reset) begin
      presc    <= '0;
      cnt      <= '0;
      tick     <= 1'b0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      presc   <= presc_next_c;
      cnt     <= cnt_next_c;
      tick    <= step_c;
      running <= run_c;
      if (clear_c) begin
        overflow <= 1'b0;
      end else if (step_c && cnt_wrap_c) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef LAP_CAPTURE_EN
  logic [CW-1:0] disp;

  // Display register: follows the live count unless frozen by a lap. Loading
  // from cnt_next_c makes a lap coincident with a tick capture the new value.
  always_ff @(posedge clk) begin
    if (!hard_reset) begin
      disp       <= '0;
      lap_active <= 1'b0;
    end else if (clear_c) begin
      disp       <= '0;
      lap_active <= 1'b0;
    end else begin
      if (lap) begin
        lap_active <= ~lap_active;
      end
      if (lap || !lap_active) begin
        disp <= cnt_next_c;
      end
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = disp;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = cnt;
`endif

endmodule

// File: tb/tb_stopwatch_timebase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_timebase_ctrl
// Scoreboard bench: the stimulus process runs a reference model that keeps
// elapsed centiseconds as an integer and derives the digits by division. It
// pushes the expected outputs for each edge. A monitor pops an entry after
// each edge and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_stopwatch_timebase_ctrl;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned TICK_HZ = 100;
  localparam int          DIV     = int'(CLK_HZ / TICK_HZ);
  localparam int          WRAP    = 360000;
`ifdef LAP_CAPTURE_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       hard_reset;
  logic       soft_reset;
  logic [1:0] en;
  logic       lap;
  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic       tick, running, overflow, lap_active;

  stopwatch_timebase_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .soft_reset (soft_reset),
    .en         (en),
    .lap        (lap),
    .cs_ones    (cs_ones),
    .cs_tens    (cs_tens),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .tick       (tick),
    .running    (running),
    .overflow   (overflow),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] digits;
    logic        tick;
    logic        running;
    logic        overflow;
    logic        lap_active;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_x;
  int          errors = 0;
  int          checks = 0;
  logic [23:0] preload_val;

  // Reference model state: elapsed centiseconds, cycles into the current period.
  int m_phase = 0;
  int m_n     = 0;
  int m_snap  = 0;
  bit m_tick  = 1'b0;
  bit m_run   = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_la    = 1'b0;

  function automatic logic [23:0] to_digits(input int v);
    int cs, s, m;
    cs = v % 100;
    s  = (v / 100) % 60;
    m  = (v / 6000) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic model_clear();
    m_phase = 0; m_n = 0; m_snap = 0;
    m_tick = 1'b0; m_run = 1'b0; m_ovf = 1'b0; m_la = 1'b0;
  endtask

  task automatic model(input logic hr, input logic sr, input logic [1:0] e, input logic l);
    if (!hr || !sr || e == 2'b00 || e == 2'b11) begin
      model_clear();
    end else begin
      m_tick = 1'b0;
      m_run  = (e == 2'b01);
      if (e == 2'b01) begin
        m_phase++;
        if (m_phase == DIV) begin
          m_phase = 0;
          m_tick  = 1'b1;
          m_n++;
          if (m_n == WRAP) begin
            m_n   = 0;
            m_ovf = 1'b1;
          end
        end
      end
      if (l && LAP_EN) begin
        m_la   = !m_la;
        m_snap = m_n;
      end
    end
  endtask

  // Apply inputs for the coming edge and queue what the DUT must show after it.
  task automatic drive_push(input logic hr, input logic sr, input logic [1:0] e, input logic l);
    exp_t x;
    hard_reset = hr; soft_reset = sr; en = e; lap = l;
    model(hr, sr, e, l);
    x.digits     = to_digits(m_la ? m_snap : m_n);
    x.tick       = m_tick;
    x.running    = m_run;
    x.overflow   = m_ovf;
    x.lap_active = m_la;
    sb_q.push_back(x);
  endtask

  task automatic step(input logic hr, input logic sr, input logic [1:0] e, input logic l);
    @(negedge clk);
    drive_push(hr, sr, e, l);
  endtask

  // Load the count with v while holding, so the wrap is reachable quickly.
  task automatic preload(input int v);
    @(negedge clk);
    preload_val = to_digits(v);
    force dut.cnt = preload_val;
    drive_push(1'b1, 1'b1, 2'b10, 1'b0);
    m_n = v;
    sb_q[sb_q.size() - 1].digits = to_digits(v);
    @(negedge clk);
    release dut.cnt;
    drive_push(1'b1, 1'b1, 2'b10, 1'b0);
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_x = sb_q.pop_front();
      check("digits", {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}, mon_x.digits);
      check("tick", 24'(tick), 24'(mon_x.tick));
      check("running", 24'(running), 24'(mon_x.running));
      check("overflow", 24'(overflow), 24'(mon_x.overflow));
      check("lap_active", 24'(lap_active), 24'(mon_x.lap_active));
    end
  end

  initial begin
    int          r;
    logic [1:0]  re;
    hard_reset = 1'b0; soft_reset = 1'b1; en = 2'b01; lap = 1'b0;
    preload_val = '0;

    // Reset with en=01, then first tick DIV cycles after release.
    repeat (3) step(1'b0, 1'b1, 2'b01, 1'b0);
    repeat (25) step(1'b1, 1'b1, 2'b01, 1'b0);

    // From clear, 1000 ticks -> 00:10.00.
    step(1'b1, 1'b1, 2'b00, 1'b0);
    repeat (1000 * DIV) step(1'b1, 1'b1, 2'b01, 1'b0);

    // Partial period preserved across a hold.
    step(1'b1, 1'b1, 2'b00, 1'b0);
    repeat (4) step(1'b1, 1'b1, 2'b01, 1'b0);
    repeat (50) step(1'b1, 1'b1, 2'b10, 1'b0);
    repeat (12) step(1'b1, 1'b1, 2'b01, 1'b0);

    // Full wrap from 59:59.90 sets overflow; idle clears it.
    step(1'b1, 1'b1, 2'b00, 1'b0);
    repeat (3) step(1'b1, 1'b1, 2'b01, 1'b0);
    preload(359990);
    repeat (12 * DIV) step(1'b1, 1'b1, 2'b01, 1'b0);
    repeat (3) step(1'b1, 1'b1, 2'b00, 1'b0);

    // soft_reset mid-count, then en=11 as idle.
    repeat (37) step(1'b1, 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b0, 2'b01, 1'b0);
    repeat (25) step(1'b1, 1'b1, 2'b01, 1'b0);
    repeat (3) step(1'b1, 1'b1, 2'b11, 1'b0);
    repeat (15) step(1'b1, 1'b1, 2'b01, 1'b0);

    // Lap capture at 00:01.23, release at 00:02.00, ignored in idle.
    step(1'b1, 1'b1, 2'b00, 1'b0);
    for (int k = 0; k < 2000 && m_n != 123; k++) step(1'b1, 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b1, 2'b01, 1'b1);
    for (int k = 0; k < 2000 && m_n != 200; k++) step(1'b1, 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b1, 2'b01, 1'b1);
    repeat (20) step(1'b1, 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b1, 2'b10, 1'b1);
    repeat (5) step(1'b1, 1'b1, 2'b10, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b0);
    step(1'b1, 1'b1, 2'b00, 1'b1);
    repeat (3) step(1'b1, 1'b1, 2'b00, 1'b0);

    // Randomized traffic, biased toward running.
    repeat (4000) begin
      r  = int'($urandom_range(0, 99));
      re = (r < 70) ? 2'b01 : (r < 85) ? 2'b10 : (r < 93) ? 2'b00 : 2'b11;
      step($urandom_range(0, 499) != 0, $urandom_range(0, 199) != 0, re,
           $urandom_range(0, 29) == 0);
    end

    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
